// File: rtl/write_ddr_burst_ctrl.sv
// write_ddr_burst_ctrl
// Drains the write-side prefetch FIFO into single-outstanding AXI4 write bursts.
// Bursts land in a ring of NUM_BUF frame buffers. wr_buf_idx tells the read-out
// path which buffer is being (or was last) written.
module write_ddr_burst_ctrl #(
  parameter int unsigned           DATA_WIDTH   = 256,
  parameter int unsigned           ADDR_WIDTH   = 28,
  parameter int unsigned           BURST_LEN    = 16,
  parameter int unsigned           FRAME_BEATS  = 57600,
  parameter int unsigned           NUM_BUF      = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 28'h000_0000,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = 28'h020_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    wr_enable,
  input  logic                    fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  output logic                    fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  output logic [1:0]              wr_buf_idx,
  output logic                    frame_done,
  output logic                    err_overrun,
  output logic                    err_bresp
);

  localparam int unsigned BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int unsigned BEAT_W         = $clog2(FRAME_BEATS + 1);
  localparam logic [1:0]  LAST_IDX       = 2'(NUM_BUF - 1);
  localparam logic [BEAT_W-1:0] FRAME_END = BEAT_W'(FRAME_BEATS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_AW,
    ST_W,
    ST_B
  } state_t;

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [7:0]              burst_cnt_q, burst_cnt_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [7:0]              awlen_q, awlen_d;
  logic                    awvalid_q, awvalid_d;
  logic [1:0]              wr_buf_idx_q, wr_buf_idx_d;
  logic                    frame_done_q, frame_done_d;
  logic                    err_overrun_q, err_overrun_d;
  logic                    err_bresp_q, err_bresp_d;

  logic [31:0]             remain_beats;
  logic [31:0]             next_len;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic                    w_accept;
  logic                    last_beat;

  // Start address and length of the next burst, derived from buffer index and frame progress.
  // Offsets advance in whole bursts, so at defaults no burst can cross a 4 KB boundary.
  assign remain_beats = FRAME_BEATS - 32'(beat_cnt_q);
  assign next_len     = (remain_beats < BURST_LEN) ? remain_beats : BURST_LEN;
  assign next_addr    = BASE_ADDR
                      + ADDR_WIDTH'(wr_buf_idx_q) * FRAME_STRIDE
                      + ADDR_WIDTH'(beat_cnt_q) * ADDR_WIDTH'(BYTES_PER_BEAT);

  // Write channel is a pass-through of the FIFO head; a pop happens exactly on an accepted beat.
  assign axi_wvalid = (state_q == ST_W) && fifo_rd_vld;
  assign w_accept   = axi_wvalid && axi_wready;
  assign last_beat  = (burst_cnt_q == awlen_q);
  assign axi_wlast  = (state_q == ST_W) && last_beat;
  assign fifo_rd_en = w_accept;
  assign axi_wdata  = fifo_rd_data;
  assign axi_wstrb  = '1;
  assign axi_bready = (state_q == ST_B);

  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awvalid = awvalid_q;
  assign wr_buf_idx  = wr_buf_idx_q;
  assign frame_done  = frame_done_q;
  assign err_overrun = err_overrun_q;
  assign err_bresp   = err_bresp_q;

  // Next-state and next-register decode; a frame_start outside IDLE is flagged and dropped.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    burst_cnt_d   = burst_cnt_q;
    awaddr_d      = awaddr_q;
    awlen_d       = awlen_q;
    awvalid_d     = awvalid_q;
    wr_buf_idx_d  = wr_buf_idx_q;
    frame_done_d  = 1'b0;
    err_bresp_d   = 1'b0;
    err_overrun_d = frame_start && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          wr_buf_idx_d = (wr_buf_idx_q == LAST_IDX) ? 2'd0 : wr_buf_idx_q + 2'd1;
          beat_cnt_d   = '0;
          burst_cnt_d  = '0;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wr_enable && fifo_rd_vld) begin
          awaddr_d  = next_addr;
          awlen_d   = 8'(next_len - 32'd1);
          awvalid_d = 1'b1;
          state_d   = ST_AW;
        end
      end
      ST_AW: begin
        if (axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (w_accept) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (last_beat) begin
            burst_cnt_d = '0;
            state_d     = ST_B;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end
      end
      ST_B: begin
        if (axi_bvalid) begin
          err_bresp_d = (axi_bresp != 2'b00);
          if (beat_cnt_q == FRAME_END) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset leaves the ring pointing at the last buffer so frame 0 uses buffer 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      beat_cnt_q    <= '0;
      burst_cnt_q   <= '0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      awvalid_q     <= 1'b0;
      wr_buf_idx_q  <= LAST_IDX;
      frame_done_q  <= 1'b0;
      err_overrun_q <= 1'b0;
      err_bresp_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      awvalid_q     <= awvalid_d;
      wr_buf_idx_q  <= wr_buf_idx_d;
      frame_done_q  <= frame_done_d;
      err_overrun_q <= err_overrun_d;
      err_bresp_q   <= err_bresp_d;
    end
  end

endmodule

// File: tb/tb_write_ddr_burst_ctrl.sv
// tb_write_ddr_burst_ctrl
// Directed bench: 40-beat frames, 16-beat bursts, 3 buffers spaced 0x1000 apart.
module tb_write_ddr_burst_ctrl;

  logic         clk;
  logic         rst_n;
  logic         frame_start;
  logic         wr_enable;
  logic         fifo_rd_vld;
  logic [255:0] fifo_rd_data;
  logic         fifo_rd_en;
  logic [27:0]  axi_awaddr;
  logic [7:0]   axi_awlen;
  logic         axi_awvalid;
  logic         axi_awready;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_wvalid;
  logic         axi_wready;
  logic [1:0]   axi_bresp;
  logic         axi_bvalid;
  logic         axi_bready;
  logic [1:0]   wr_buf_idx;
  logic         frame_done;
  logic         err_overrun;
  logic         err_bresp;

  write_ddr_burst_ctrl #(
    .DATA_WIDTH   (256),
    .ADDR_WIDTH   (28),
    .BURST_LEN    (16),
    .FRAME_BEATS  (40),
    .NUM_BUF      (3),
    .BASE_ADDR    (28'h000_0000),
    .FRAME_STRIDE (28'h000_1000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .wr_enable    (wr_enable),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .axi_awaddr   (axi_awaddr),
    .axi_awlen    (axi_awlen),
    .axi_awvalid  (axi_awvalid),
    .axi_awready  (axi_awready),
    .axi_wdata    (axi_wdata),
    .axi_wstrb    (axi_wstrb),
    .axi_wlast    (axi_wlast),
    .axi_wvalid   (axi_wvalid),
    .axi_wready   (axi_wready),
    .axi_bresp    (axi_bresp),
    .axi_bvalid   (axi_bvalid),
    .axi_bready   (axi_bready),
    .wr_buf_idx   (wr_buf_idx),
    .frame_done   (frame_done),
    .err_overrun  (err_overrun),
    .err_bresp    (err_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int unsigned n);
    return {8{32'(n) ^ 32'h5A5A_0000}};
  endfunction

  // FIFO head data is a numbered pattern; the number advances on each pop.
  int unsigned pop_cnt = 0;
  assign fifo_rd_data = pat(pop_cnt);

  // Slave/FIFO model state
  logic        stall_mode = 1'b0;
  int unsigned burst_no   = 0;
  int unsigned err_burst  = 0;
  int unsigned exp_beat   = 0;
  int unsigned beat_in    = 0;
  int unsigned wlast_cnt  = 0;
  int unsigned done_cnt   = 0;
  int unsigned ovr_cnt    = 0;
  int unsigned berr_cnt   = 0;
  logic [7:0]  cur_len    = 8'd0;
  logic        w_phase    = 1'b0;
  logic        b_phase    = 1'b0;
  logic        b_pending  = 1'b0;
  logic        aw_pend    = 1'b0;
  logic [27:0] hold_addr  = '0;
  logic [7:0]  hold_len   = '0;
  logic [27:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];

  // Observe at the falling edge what the next rising edge will sample, then drive after that edge.
  initial begin
    logic pop;
    fifo_rd_vld = 1'b0;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = 2'b00;
    forever begin
      @(negedge clk);
      pop = 1'b0;
      if (!rst_n) begin
        w_phase = 1'b0; b_phase = 1'b0; b_pending = 1'b0; aw_pend = 1'b0;
        beat_in = 0; exp_beat = pop_cnt;
      end else begin
        chk("wvalid", 256'(axi_wvalid), 256'(w_phase && fifo_rd_vld));
        chk("rd_en", 256'(fifo_rd_en), 256'(w_phase && fifo_rd_vld && axi_wready));
        chk("bready", 256'(axi_bready), 256'(b_phase));
        if (!w_phase) chk("wlast_idle", 256'(axi_wlast), 256'd0);
        if (aw_pend) begin
          chk("aw_hold_valid", 256'(axi_awvalid), 256'd1);
          chk("aw_hold_addr", 256'(axi_awaddr), 256'(hold_addr));
          chk("aw_hold_len", 256'(axi_awlen), 256'(hold_len));
        end
        pop = fifo_rd_en;
        aw_pend = axi_awvalid && !axi_awready;
        hold_addr = axi_awaddr;
        hold_len = axi_awlen;
        if (axi_awvalid && axi_awready) begin
          aw_addr_q.push_back(axi_awaddr);
          aw_len_q.push_back(axi_awlen);
          cur_len = axi_awlen;
          burst_no++;
          beat_in = 0;
          w_phase = 1'b1;
        end
        if (axi_wvalid && axi_wready) begin
          chk("wdata", axi_wdata, pat(exp_beat));
          chk("wstrb", 256'(axi_wstrb), 256'(32'hFFFF_FFFF));
          chk("wlast", 256'(axi_wlast), 256'(beat_in == 32'(cur_len)));
          exp_beat++;
          if (beat_in == 32'(cur_len)) begin
            w_phase = 1'b0; b_phase = 1'b1; b_pending = 1'b1;
            wlast_cnt++;
          end else begin
            beat_in++;
          end
        end
        if (axi_bvalid && axi_bready) begin
          b_phase = 1'b0;
          b_pending = 1'b0;
        end
        done_cnt += 32'(frame_done);
        ovr_cnt  += 32'(err_overrun);
        berr_cnt += 32'(err_bresp);
      end
      @(posedge clk);
      #1;
      if (pop && rst_n) pop_cnt++;
      fifo_rd_vld = stall_mode ? !fifo_rd_vld : 1'b1;
      axi_wready  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_awready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_bvalid  = b_pending;
      axi_bresp   = (b_pending && burst_no == err_burst) ? 2'b10 : 2'b00;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst_awvalid", 256'(axi_awvalid), 256'd0);
    chk("rst_awaddr", 256'(axi_awaddr), 256'd0);
    chk("rst_awlen", 256'(axi_awlen), 256'd0);
    chk("rst_wvalid", 256'(axi_wvalid), 256'd0);
    chk("rst_wlast", 256'(axi_wlast), 256'd0);
    chk("rst_bready", 256'(axi_bready), 256'd0);
    chk("rst_rd_en", 256'(fifo_rd_en), 256'd0);
    chk("rst_done", 256'(frame_done), 256'd0);
    chk("rst_overrun", 256'(err_overrun), 256'd0);
    chk("rst_bresp_err", 256'(err_bresp), 256'd0);
    chk("rst_buf_idx", 256'(wr_buf_idx), 256'd2);
  endtask

  int unsigned pops0, done0, ovr0, berr0, wl0;

  // Clear logs, snapshot counters, pulse frame_start for one cycle; returns one cycle into REQ.
  task automatic start_frame();
    aw_addr_q.delete();
    aw_len_q.delete();
    pops0 = pop_cnt; done0 = done_cnt; ovr0 = ovr_cnt; berr0 = berr_cnt; wl0 = wlast_cnt;
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Wait (bounded) for frame_done, then check the three bursts and the frame bookkeeping.
  task automatic finish_frame(input string name, input logic [27:0] base, input logic [1:0] idx,
                              input int unsigned exp_ovr, input int unsigned exp_berr);
    logic [27:0] offs [3];
    logic [7:0]  lens [3];
    offs = '{28'h000, 28'h200, 28'h400};
    lens = '{8'd15, 8'd15, 8'd7};
    for (int i = 0; i < 2000 && done_cnt == done0; i++) step();
    sample();
    chk({name, "_done"}, 256'(done_cnt - done0), 256'd1);
    chk({name, "_bursts"}, 256'(aw_addr_q.size()), 256'd3);
    for (int j = 0; j < 3; j++) begin
      if (aw_addr_q.size() > j) begin
        chk({name, "_awaddr"}, 256'(aw_addr_q[j]), 256'(base + offs[j]));
        chk({name, "_awlen"}, 256'(aw_len_q[j]), 256'(lens[j]));
      end
    end
    chk({name, "_pops"}, 256'(pop_cnt - pops0), 256'd40);
    chk({name, "_wlasts"}, 256'(wlast_cnt - wl0), 256'd3);
    chk({name, "_overrun"}, 256'(ovr_cnt - ovr0), 256'(exp_ovr));
    chk({name, "_bresp_err"}, 256'(berr_cnt - berr0), 256'(exp_berr));
    chk({name, "_buf_idx"}, 256'(wr_buf_idx), 256'(idx));
    $display("frame %s: buf %0d first awaddr 0x%0h, %0d bursts, %0d pops", name, wr_buf_idx,
             (aw_addr_q.size() > 0) ? aw_addr_q[0] : 28'h0, aw_addr_q.size(), pop_cnt - pops0);
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    wr_enable = 1'b1;
    repeat (3) step();
    sample();
    check_reset();
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Frame 1: no stalls, awvalid two cycles after the frame_start cycle.
    start_frame();
    sample();
    chk("f1_awvalid_c1", 256'(axi_awvalid), 256'd0);
    step();
    sample();
    chk("f1_awvalid_c2", 256'(axi_awvalid), 256'd1);
    finish_frame("f1", 28'h0000, 2'd0, 0, 0);

    // Frame 2: toggling FIFO valid, random wready/awready.
    stall_mode = 1'b1;
    start_frame();
    finish_frame("f2", 28'h1000, 2'd1, 0, 0);
    stall_mode = 1'b0;
    step();

    // Frame 3: frame_start during W is flagged and ignored.
    start_frame();
    sample();
    for (int i = 0; i < 50 && !axi_wvalid; i++) begin step(); sample(); end
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    sample();
    chk("f3_idx_after_ovr", 256'(wr_buf_idx), 256'd2);
    finish_frame("f3", 28'h2000, 2'd2, 1, 0);

    // Frame 4: SLVERR on the second burst; ring wraps back to buffer 0.
    err_burst = burst_no + 2;
    start_frame();
    finish_frame("f4", 28'h0000, 2'd0, 0, 1);
    err_burst = 0;

    // Frame 5: wr_enable low holds REQ; raising it gives awvalid one cycle later.
    wr_enable = 1'b0;
    start_frame();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("f5_blocked_awvalid", 256'(axi_awvalid), 256'd0);
      step();
    end
    wr_enable = 1'b1;
    sample();
    chk("f5_en_awvalid_n", 256'(axi_awvalid), 256'd0);
    step();
    sample();
    chk("f5_en_awvalid_n1", 256'(axi_awvalid), 256'd1);
    finish_frame("f5", 28'h1000, 2'd1, 0, 0);

    // Frame 6: reset in the middle of a W burst.
    start_frame();
    sample();
    for (int i = 0; i < 50 && !axi_wvalid; i++) begin step(); sample(); end
    rst_n = 1'b0;
    sample();
    check_reset();
    $display("reset mid-burst: buf_idx %0d awvalid %0d wvalid %0d", wr_buf_idx, axi_awvalid, axi_wvalid);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Frame 7: after reset the ring starts again at buffer 0.
    start_frame();
    finish_frame("f7", 28'h0000, 2'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
